// File: rtl/pcgen.sv
// PC generator: issues one fetch PC at a time to the IFU, follows the IFU's
// returned PC (+4), and handles redirects with a registered flush pulse.
// Optional performance counters are built when PCGEN_PERF_EN is defined.

package offnariscv_pkg;
   localparam int XLEN = 32;
endpackage

module pcgen #(
   parameter int              XLEN         = offnariscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] next_pc_tdata,
   output logic            next_pc_tvalid,
   input  logic            next_pc_tready,
   input  logic [XLEN-1:0] current_pc_tdata,
   input  logic            current_pc_tvalid,
   output logic            current_pc_tready,
   input  logic [XLEN-1:0] redirect_tdata,
   input  logic            redirect_tvalid,
   output logic            invalidate,
   output logic [63:0]     perf_issued,
   output logic [63:0]     perf_redirects
);

   typedef enum logic [1:0] {
      RESET = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_reg, pc_d;
   logic            invalidate_q;
   logic            issue_fire;
   logic            return_fire;
   logic            redirect_take;

   assign issue_fire    = next_pc_tvalid && next_pc_tready;
   assign return_fire   = current_pc_tvalid && current_pc_tready;
   assign redirect_take = redirect_tvalid && (state_q != RESET);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RESET;
         pc_reg       <= RESET_VECTOR;
         invalidate_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_reg       <= pc_d;
         invalidate_q <= (state_d == FLUSH);
      end
   end

   // A redirect overrides any handshake in the same cycle; a returned PC
   // only counts while actually waiting for it, otherwise it is a stale beat.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_reg;
      if (redirect_take) begin
         state_d = FLUSH;
         pc_d    = redirect_tdata & ~XLEN'(3);
      end else begin
         unique case (state_q)
            RESET: state_d = ISSUE;
            ISSUE: if (issue_fire) state_d = WAIT;
            WAIT: begin
               if (return_fire) begin
                  state_d = ISSUE;
                  pc_d    = current_pc_tdata + XLEN'(4);
               end
            end
            FLUSH: state_d = ISSUE;
            default: state_d = RESET;
         endcase
      end
   end

   always_comb begin
      next_pc_tvalid    = (state_q == ISSUE);
      next_pc_tdata     = pc_reg;
      current_pc_tready = (state_q != RESET);
      invalidate        = invalidate_q;
   end

`ifdef PCGEN_PERF_EN
   logic [63:0] issued_cnt;
   logic [63:0] redirect_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt   <= 64'd0;
         redirect_cnt <= 64'd0;
      end else begin
         if (issue_fire)    issued_cnt   <= issued_cnt + 64'd1;
         if (redirect_take) redirect_cnt <= redirect_cnt + 64'd1;
      end
   end

   assign perf_issued    = issued_cnt;
   assign perf_redirects = redirect_cnt;
`else
   assign perf_issued    = 64'd0;
   assign perf_redirects = 64'd0;
`endif

endmodule

// File: tb/tb_pcgen.sv
// Directed bench for pcgen: reset, back-pressure, echo sequencing, wrap,
// redirects (including redirect during FLUSH) and perf counters.
module tb_pcgen;

   logic        clk;
   logic        rst;
   logic [31:0] next_pc_tdata;
   logic        next_pc_tvalid;
   logic        next_pc_tready;
   logic [31:0] current_pc_tdata;
   logic        current_pc_tvalid;
   logic        current_pc_tready;
   logic [31:0] redirect_tdata;
   logic        redirect_tvalid;
   logic        invalidate;
   logic [63:0] perf_issued;
   logic [63:0] perf_redirects;

   int total_checks = 0;
   int bad_checks   = 0;

   pcgen dut (
      .clk               (clk),
      .rst               (rst),
      .next_pc_tdata     (next_pc_tdata),
      .next_pc_tvalid    (next_pc_tvalid),
      .next_pc_tready    (next_pc_tready),
      .current_pc_tdata  (current_pc_tdata),
      .current_pc_tvalid (current_pc_tvalid),
      .current_pc_tready (current_pc_tready),
      .redirect_tdata    (redirect_tdata),
      .redirect_tvalid   (redirect_tvalid),
      .invalidate        (invalidate),
      .perf_issued       (perf_issued),
      .perf_redirects    (perf_redirects)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Drive inputs for one cycle, then land just after the rising edge.
   task automatic applyStimulus(input logic rdy, input logic cur_v, input logic [31:0] cur_d,
                                input logic red_v, input logic [31:0] red_d);
      next_pc_tready    = rdy;
      current_pc_tvalid = cur_v;
      current_pc_tdata  = cur_d;
      redirect_tvalid   = red_v;
      redirect_tdata    = red_d;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_pc;
   logic [63:0] exp_issued;
   logic [63:0] exp_redirects;

   initial begin
      rst = 1'b1;
      next_pc_tready = 1'b0; current_pc_tvalid = 1'b0; current_pc_tdata = '0;
      redirect_tvalid = 1'b0; redirect_tdata = '0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("rst_tvalid", 64'(next_pc_tvalid), 64'd0);
      checkOutput("rst_cur_tready", 64'(current_pc_tready), 64'd0);
      checkOutput("rst_invalidate", 64'(invalidate), 64'd0);
      checkOutput("rst_perf_issued", perf_issued, 64'd0);

      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("first_tvalid", 64'(next_pc_tvalid), 64'd1);
      checkOutput("first_tdata", 64'(next_pc_tdata), 64'h8000_0000);
      checkOutput("first_cur_tready", 64'(current_pc_tready), 64'd1);

      // Back-pressure: five stalled cycles, handshake on the sixth.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         checkOutput("stall_tvalid", 64'(next_pc_tvalid), 64'd1);
         checkOutput("stall_tdata", 64'(next_pc_tdata), 64'h8000_0000);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wait_tvalid", 64'(next_pc_tvalid), 64'd0);

      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
      checkOutput("echo1_tvalid", 64'(next_pc_tvalid), 64'd1);
      checkOutput("echo1_tdata", 64'(next_pc_tdata), 64'h8000_0004);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("echo1_wait", 64'(next_pc_tvalid), 64'd0);
      applyStimulus(1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0);
      checkOutput("echo2_tdata", 64'(next_pc_tdata), 64'h8000_0008);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

      // Redirect while waiting, then a stale returned PC during FLUSH.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_1003);
      checkOutput("redir_inv", 64'(invalidate), 64'd1);
      checkOutput("redir_tvalid", 64'(next_pc_tvalid), 64'd0);
      applyStimulus(1'b0, 1'b1, 32'h8000_0008, 1'b0, 32'h0);
      checkOutput("redir_inv_drop", 64'(invalidate), 64'd0);
      checkOutput("redir_target", 64'(next_pc_tdata), 64'h8000_1000);
      checkOutput("redir_tvalid2", 64'(next_pc_tvalid), 64'd1);
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
      checkOutput("stale_issue_tdata", 64'(next_pc_tdata), 64'h8000_1000);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      checkOutput("wrap_tdata", 64'(next_pc_tdata), 64'h0000_0000);

      // Redirect together with a next_pc handshake, then a second redirect in FLUSH.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_2000);
      checkOutput("dbl_inv1", 64'(invalidate), 64'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_3006);
      checkOutput("dbl_inv2", 64'(invalidate), 64'd1);
      checkOutput("dbl_tvalid", 64'(next_pc_tvalid), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("dbl_inv_off", 64'(invalidate), 64'd0);
      checkOutput("dbl_target", 64'(next_pc_tdata), 64'h8000_3004);

      // Five issues so far; five more echoed round trips.
      exp_pc = 32'h8000_3004;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         applyStimulus(1'b0, 1'b1, exp_pc, 1'b0, 32'h0);
         exp_pc = exp_pc + 32'd4;
         checkOutput("loop_tdata", 64'(next_pc_tdata), 64'(exp_pc));
      end
`ifdef PCGEN_PERF_EN
      exp_issued = 64'd10; exp_redirects = 64'd3;
`else
      exp_issued = 64'd0; exp_redirects = 64'd0;
`endif
      checkOutput("perf_issued", perf_issued, exp_issued);
      checkOutput("perf_redirects", perf_redirects, exp_redirects);

      // Redirect together with a current_pc handshake: the returned PC is flushed.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_4000);
      checkOutput("cur_redir_inv", 64'(invalidate), 64'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("cur_redir_target", 64'(next_pc_tdata), 64'h8000_4000);

      // Reset mid-operation beats a simultaneous redirect.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_5000);
      checkOutput("midrst_tvalid", 64'(next_pc_tvalid), 64'd0);
      checkOutput("midrst_inv", 64'(invalidate), 64'd0);
      checkOutput("midrst_cur_tready", 64'(current_pc_tready), 64'd0);
      checkOutput("midrst_perf", perf_issued | perf_redirects, 64'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("midrst_restart", 64'(next_pc_tdata), 64'h8000_0000);
      checkOutput("midrst_restart_v", 64'(next_pc_tvalid), 64'd1);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
